// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: shared definitions for the multi-channel timer peripheral.
//   - register offsets within a 16-byte channel window
//   - TCON bit positions
//   - per-channel write-strobe and TCON view structs
//   - irq_stat_ofs(): offset of the global IRQ_STAT register
package timer_bank_pkg;

    localparam logic [3:0] TH_OFS    = 4'h0;
    localparam logic [3:0] TL_OFS    = 4'h4;
    localparam logic [3:0] TCON_OFS  = 4'h8;
    localparam logic [3:0] PRE_OFS   = 4'hC;
    localparam int         CH_STRIDE = 16;

    localparam int TCON_EN      = 0;
    localparam int TCON_IE      = 1;
    localparam int TCON_PEND    = 2;
    localparam int TCON_ONESHOT = 3;
    localparam int TCON_CASCADE = 4;

    // One strobe per channel register, decoded by the top level.
    typedef struct packed {
        logic th;
        logic tl;
        logic tcon;
        logic pre;
    } ch_wr_t;

    // Read-back view of TCON, bit 0 (en) is the LSB.
    typedef struct packed {
        logic cascade;
        logic oneshot;
        logic pend;
        logic ie;
        logic en;
    } tcon_t;

    // IRQ_STAT sits directly after the last channel window.
    function automatic logic [31:0] irq_stat_ofs(input int num_ch);
        return 32'(num_ch * CH_STRIDE);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one reload timer (TH/TL/TCON/PRE plus prescaler counter).
// Optional feature macro: TIMER_CASCADE_EN (adds the cascade bit, the
// casc_tick input and the HAS_CASC parameter).
// Ports:
//   clk, reset      clock, async active-low reset
//   wr              per-register write strobes (ch_wr_t)
//   wdata[31:0]     write data
//   casc_tick       previous channel's overflow pulse (cascade build only)
//   th, tl, pre     register contents
//   tcon            TCON read view
//   ovf             single-cycle overflow pulse
//   pend, ie        interrupt pending / enable bits
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
`ifdef TIMER_CASCADE_EN
   ,parameter bit HAS_CASC = 1'b0
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  ch_wr_t           wr,
    input  logic [31:0]      wdata,
`ifdef TIMER_CASCADE_EN
    input  logic             casc_tick,
`endif
    output logic [CNT_W-1:0] th,
    output logic [CNT_W-1:0] tl,
    output logic [PRE_W-1:0] pre,
    output tcon_t            tcon,
    output logic             ovf,
    output logic             pend,
    output logic             ie
);

    logic [PRE_W-1:0] pc;
    logic             en, oneshot;
    logic             src_tick, pc_hold, tick;

`ifdef TIMER_CASCADE_EN
    logic casc_bit, casc_act;
    // Channel 0 has no predecessor, so its cascade bit is stored but inert.
    assign casc_act = HAS_CASC && casc_bit;
    assign src_tick = casc_act ? casc_tick : (pc == pre);
    assign pc_hold  = casc_act;
    assign tcon     = '{cascade: casc_bit, oneshot: oneshot, pend: pend, ie: ie, en: en};
`else
    assign src_tick = (pc == pre);
    assign pc_hold  = 1'b0;
    assign tcon     = '{cascade: 1'b0, oneshot: oneshot, pend: pend, ie: ie, en: en};
`endif

    // A software write to TH or TL swallows a coincident tick entirely.
    assign tick = en && src_tick && !(wr.th || wr.tl);
    assign ovf  = tick && (tl == '1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= '0;
        else if (!en || wr.pre || pc_hold || pc == pre)
            pc <= '0;
        else
            pc <= pc + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            pre     <= '0;
            en      <= 1'b0;
            ie      <= 1'b0;
            pend    <= 1'b0;
            oneshot <= 1'b0;
`ifdef TIMER_CASCADE_EN
            casc_bit <= 1'b0;
`endif
        end else begin
            if (wr.th)  th  <= wdata[CNT_W-1:0];
            if (wr.pre) pre <= wdata[PRE_W-1:0];

            if (wr.tl)     tl <= wdata[CNT_W-1:0];
            else if (ovf)  tl <= th;
            else if (tick) tl <= tl + 1'b1;

            if (wr.tcon) begin
                en      <= wdata[TCON_EN];
                ie      <= wdata[TCON_IE];
                oneshot <= wdata[TCON_ONESHOT];
`ifdef TIMER_CASCADE_EN
                casc_bit <= wdata[TCON_CASCADE];
`endif
            end
            // One-shot stop overrides any en written in the same cycle.
            if (ovf && oneshot) en <= 1'b0;

            // Set beats W1C.
            if (ovf)                                pend <= 1'b1;
            else if (wr.tcon && wdata[TCON_PEND])   pend <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH memory-mapped reload timers with one level interrupt.
// Optional feature macro: TIMER_CASCADE_EN (channel c>=1 may count channel
// c-1 overflows instead of prescaler ticks).
// Ports:
//   clk, reset    clock, async active-low reset
//   rd, wr        bus read / write strobes
//   addr[31:0]    byte address
//   wdata[31:0]   write data
//   rdata[31:0]   combinational read data, 0 when rd=0 or unmapped
//   irqout        OR over channels of (pend & ie), driven from registers only
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          CNT_W     = 32,
    parameter int          PRE_W     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    logic [31:0] off;
    logic        ch_hit, stat_hit;
    logic [2:0]  ch_sel;
    logic [3:0]  reg_ofs;

    // Addresses below BASE_ADDR wrap to huge offsets and miss both windows.
    assign off      = addr - BASE_ADDR;
    assign ch_hit   = off < 32'(NUM_CH * CH_STRIDE);
    assign stat_hit = off == irq_stat_ofs(NUM_CH);
    assign ch_sel   = off[6:4];
    assign reg_ofs  = off[3:0];

    logic  [NUM_CH-1:0][CNT_W-1:0] th_q, tl_q;
    logic  [NUM_CH-1:0][PRE_W-1:0] pre_q;
    tcon_t [NUM_CH-1:0]            tcon_q;
    logic  [NUM_CH-1:0]            ovf, pend, ie;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic   sel;
        ch_wr_t wstb;

        assign sel       = wr && ch_hit && (ch_sel == 3'(c));
        assign wstb.th   = sel && (reg_ofs == TH_OFS);
        assign wstb.tl   = sel && (reg_ofs == TL_OFS);
        assign wstb.tcon = sel && (reg_ofs == TCON_OFS);
        assign wstb.pre  = sel && (reg_ofs == PRE_OFS);

`ifdef TIMER_CASCADE_EN
        logic casc_in;
        if (c == 0) begin : g_head
            assign casc_in = 1'b0;
        end else begin : g_link
            assign casc_in = ovf[c-1];
        end
`endif

        timer_channel #(
            .CNT_W    (CNT_W),
            .PRE_W    (PRE_W)
`ifdef TIMER_CASCADE_EN
           ,.HAS_CASC (c != 0)
`endif
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr        (wstb),
            .wdata     (wdata),
`ifdef TIMER_CASCADE_EN
            .casc_tick (casc_in),
`endif
            .th        (th_q[c]),
            .tl        (tl_q[c]),
            .pre       (pre_q[c]),
            .tcon      (tcon_q[c]),
            .ovf       (ovf[c]),
            .pend      (pend[c]),
            .ie        (ie[c])
        );
    end

    assign irqout = |(pend & ie);

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (stat_hit) begin
                rdata[NUM_CH-1:0] = pend;
            end else if (ch_hit) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_sel == 3'(c)) begin
                        case (reg_ofs)
                            TH_OFS:   rdata[CNT_W-1:0] = th_q[c];
                            TL_OFS:   rdata[CNT_W-1:0] = tl_q[c];
                            TCON_OFS: rdata[4:0]       = tcon_q[c];
                            PRE_OFS:  rdata[PRE_W-1:0] = pre_q[c];
                            default:  ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed self-checking bench for timer_bank (NUM_CH=2,
// CNT_W=32, PRE_W=8). Inputs change on the falling edge; writes land on the
// following rising edge; reads are sampled 1 time unit after being driven.
module tb_timer_bank;

    localparam logic [31:0] B       = 32'h40000020;
    localparam logic [31:0] C0_TH   = B + 32'h00;
    localparam logic [31:0] C0_TL   = B + 32'h04;
    localparam logic [31:0] C0_TCON = B + 32'h08;
    localparam logic [31:0] C0_PRE  = B + 32'h0C;
    localparam logic [31:0] C1_TL   = B + 32'h14;
    localparam logic [31:0] C1_TCON = B + 32'h18;
    localparam logic [31:0] C1_PRE  = B + 32'h1C;
    localparam logic [31:0] STAT    = B + 32'h20;

    logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        irqout;
    int          ncmp = 0, nfail = 0;

    timer_bank #(
        .NUM_CH(2), .CNT_W(32), .PRE_W(8), .BASE_ADDR(B)
    ) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irqout(irqout)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rdc(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        rd   = 1'b1;
        #1;
        chk(tag, rdata, exp);
        rd   = 1'b0;
    endtask

    // Called in the low phase; the write lands on the next rising edge.
    task automatic wreg(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    initial begin
        // Held in reset
        @(negedge clk);
        chk("irq_in_reset", {31'b0, irqout}, 32'h0);
        rdc("tcon_in_reset", C0_TCON, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Reset mid-count
        wreg(C0_TH, 32'hAB);
        wreg(C0_TL, 32'h5);
        wreg(C0_PRE, 32'h2);
        wreg(C0_TCON, 32'h3);
        repeat (3) @(negedge clk);
        rdc("tl_before_reset", C0_TL, 32'h6);
        reset = 1'b0;
        #1;
        rdc("th_after_reset", C0_TH, 32'h0);
        rdc("tl_after_reset", C0_TL, 32'h0);
        rdc("tcon_after_reset", C0_TCON, 32'h0);
        rdc("pre_after_reset", C0_PRE, 32'h0);
        chk("irq_after_reset", {31'b0, irqout}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // ch0 auto-reload, PRE=0, ie=1
        wreg(C0_TH, 32'hFFFFFFFC);
        wreg(C0_TL, 32'hFFFFFFFC);
        wreg(C0_PRE, 32'h0);
        wreg(C0_TCON, 32'h3);
        repeat (3) @(negedge clk);
        rdc("ar_tl_pre_ovf", C0_TL, 32'hFFFFFFFF);
        chk("ar_irq_pre_ovf", {31'b0, irqout}, 32'h0);
        @(negedge clk);
        rdc("ar_tl_reload", C0_TL, 32'hFFFFFFFC);
        chk("ar_irq_set", {31'b0, irqout}, 32'h1);
        rdc("ar_tcon_pend", C0_TCON, 32'h7);
        wreg(C0_TCON, 32'h7);
        chk("ar_irq_w1c", {31'b0, irqout}, 32'h0);
        rdc("ar_tcon_w1c", C0_TCON, 32'h3);
        rdc("ar_tl_run", C0_TL, 32'hFFFFFFFD);
        wreg(C0_TCON, 32'h0);
        rdc("ar_tl_stop", C0_TL, 32'hFFFFFFFE);

        // ch1 one-shot, PRE=3, ie=0
        wreg(C1_PRE, 32'h3);
        wreg(C1_TL, 32'hFFFFFFFE);
        wreg(C1_TCON, 32'h9);
        repeat (7) @(negedge clk);
        rdc("os_tl_pre_ovf", C1_TL, 32'hFFFFFFFF);
        rdc("os_tcon_pre_ovf", C1_TCON, 32'h9);
        @(negedge clk);
        rdc("os_tcon_done", C1_TCON, 32'hC);
        rdc("os_tl_reload", C1_TL, 32'h0);
        chk("os_irq_masked", {31'b0, irqout}, 32'h0);
        rdc("irq_stat", STAT, 32'h2);
        repeat (5) @(negedge clk);
        rdc("os_tl_frozen", C1_TL, 32'h0);
        rdc("unmapped_24", B + 32'h24, 32'h0);
        rdc("unmapped_28", B + 32'h28, 32'h0);
        addr = C1_TCON;
        rd   = 1'b0;
        #1;
        chk("rd_low_zero", rdata, 32'h0);

        // Overflow coincident with W1C: pend stays set
        wreg(C0_TCON, 32'h3);
        @(negedge clk);
        wreg(C0_TCON, 32'h7);
        rdc("w1c_coll_tcon", C0_TCON, 32'h7);
        rdc("w1c_coll_tl", C0_TL, 32'hFFFFFFFC);
        chk("w1c_coll_irq", {31'b0, irqout}, 32'h1);
        wreg(C0_TCON, 32'h4);
        rdc("w1c_stop_tl", C0_TL, 32'hFFFFFFFD);
        rdc("w1c_stop_tcon", C0_TCON, 32'h0);

        // en=0 write coincident with overflow: reload and pend still happen
        wreg(C0_TL, 32'hFFFFFFFE);
        wreg(C0_TCON, 32'h1);
        @(negedge clk);
        wreg(C0_TCON, 32'h0);
        rdc("en_coll_tl", C0_TL, 32'hFFFFFFFC);
        rdc("en_coll_tcon", C0_TCON, 32'h4);
        @(negedge clk);
        rdc("en_coll_frozen", C0_TL, 32'hFFFFFFFC);

        // TL write coincident with a tick: written value wins
        wreg(C0_TCON, 32'h5);
        wreg(C0_TL, 32'h100);
        rdc("tl_coll_write", C0_TL, 32'h100);
        @(negedge clk);
        rdc("tl_coll_next", C0_TL, 32'h101);
        wreg(C0_TCON, 32'h0);
        rdc("tl_coll_stop", C0_TL, 32'h102);

        // Bits above PRE_W / TCON width are dropped
        wreg(C0_PRE, 32'hFFFFFF05);
        rdc("pre_trunc", C0_PRE, 32'h05);
        wreg(C0_TCON, 32'hFFFFFFE0);
        rdc("tcon_trunc", C0_TCON, 32'h0);

`ifdef TIMER_CASCADE_EN
        // ch1 cascaded on ch0, which overflows every cycle
        wreg(C1_TL, 32'h0);
        wreg(C1_TCON, 32'h11);
        wreg(C0_TH, 32'hFFFFFFFF);
        wreg(C0_TL, 32'hFFFFFFFF);
        wreg(C0_PRE, 32'h0);
        wreg(C0_TCON, 32'h1);
        @(negedge clk);
        rdc("casc_tl_1", C1_TL, 32'h1);
        @(negedge clk);
        rdc("casc_tl_2", C1_TL, 32'h2);
        repeat (3) @(negedge clk);
        rdc("casc_tl_5", C1_TL, 32'h5);
        rdc("casc_tcon", C1_TCON, 32'h15);
        rdc("casc_ch0_tl", C0_TL, 32'hFFFFFFFF);
`else
        // Cascade bit absent: ch1 pend from the one-shot is still set
        wreg(C1_TCON, 32'h10);
        rdc("no_casc_bit", C1_TCON, 32'h4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
